// File: rtl/dsp_opmode_sequencer.sv
// rtl/dsp_opmode_sequencer.sv - MUL/MAC command sequencer for one DSP48A1 slice
// Gates sample flow, tags each sample with its OPMODE and flags results leaving the P register.
module dsp_opmode_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic [7:0]       opmode,
  output logic             res_valid,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [1:0] MODE_MUL    = 2'd0;
  localparam logic [1:0] MODE_MAC    = 2'd1;
  localparam logic [1:0] MODE_PREADD = 2'd2;

  state_t           r_state, w_next;
  logic [1:0]       r_mode;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic             r_v1, r_v2;
  logic [7:0]       r_tag1, r_tag2, r_opm_hold;
  logic             r_rf1, r_rf2, r_lf1, r_lf2;
  logic             r_res_valid, r_res_last;

  logic             w_accept, w_first, w_last, w_res;
  logic [7:0]       w_tag;

  assign w_accept = s_valid & s_ready;
  assign w_first  = (r_cnt == '0);
  // r_len is never zero in RUN, so len-1 cannot underflow.
  assign w_last   = (r_cnt == r_len - LEN_W'(1));
  assign w_res    = (r_mode == MODE_MUL) | w_last;

  always_comb begin
    w_tag = 8'h01;
    case (r_mode)
      MODE_MUL:    w_tag = 8'h01;
      MODE_MAC:    w_tag = w_first ? 8'h01 : 8'h09;
      MODE_PREADD: w_tag = w_first ? 8'h11 : 8'h19;
      default:     w_tag = w_first ? 8'h51 : 8'h59;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = (cmd_len == '0) ? DONE : RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        if (s_valid && w_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_res_valid && r_res_last) w_next = DONE;
      end
      default: begin
        done   = 1'b1;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && cmd_valid) begin
        r_mode <= cmd_mode;
        r_len  <= cmd_len;
        r_cnt  <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end

  // Tags shift every cycle; only the valid bits decide whether a stage is enabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_tag1      <= '0;
      r_tag2      <= '0;
      r_rf1       <= 1'b0;
      r_rf2       <= 1'b0;
      r_lf1       <= 1'b0;
      r_lf2       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_opm_hold  <= '0;
    end else begin
      r_v1        <= w_accept;
      r_v2        <= r_v1;
      r_tag1      <= w_tag;
      r_tag2      <= r_tag1;
      r_rf1       <= w_res;
      r_rf2       <= r_rf1;
      r_lf1       <= w_last;
      r_lf2       <= r_lf1;
      r_res_valid <= r_v2 & r_rf2;
      r_res_last  <= r_v2 & r_rf2 & r_lf2;
      if (r_v2) r_opm_hold <= r_tag2;
    end
  end

  assign ce_ab     = w_accept;
  assign ce_m      = r_v1;
  assign ce_p      = r_v2;
  assign opmode    = r_v2 ? r_tag2 : r_opm_hold;
  assign res_valid = r_res_valid;
  assign res_last  = r_res_last;

endmodule

// File: tb/tb_dsp_opmode_sequencer.sv
// tb/tb_dsp_opmode_sequencer.sv - bench for dsp_opmode_sequencer
module tb_dsp_opmode_sequencer;
  localparam int LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic             s_valid, s_ready;
  logic             ce_ab, ce_m, ce_p;
  logic [7:0]       opmode;
  logic             res_valid, res_last, busy, done;

  dsp_opmode_sequencer #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready),
    .ce_ab(ce_ab), .ce_m(ce_m), .ce_p(ce_p), .opmode(opmode),
    .res_valid(res_valid), .res_last(res_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct { int t; logic [7:0] op; } op_exp_t;
  typedef struct { int t; logic last; } res_exp_t;
  typedef struct {
    logic [1:0] mode; int len; bit gap;
    logic [7:0] op_first; logic [7:0] op_rest; int exp_res;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  int cem_q[$];
  op_exp_t op_q[$];
  res_exp_t res_q[$];

  logic [7:0] m_first_op, m_rest_op, m_last_op = 8'h00;
  int  m_len = 0, m_idx = 0, m_res_cnt = 0, m_done_cnt = 0, m_cmd_acc = 0;
  int  m_cmd_cyc = 0, m_done_cyc = 0, m_lastres_cyc = 0;
  bit  m_mul = 1'b0, m_in_run = 1'b0;
  vec_t vecs[10];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event without expected entry (cycle %0d)", name, cyc);
  endtask

  // Scoreboard: accepts push expected ce_m/ce_p/result events, DUT outputs pop them.
  always @(negedge CLK) begin
    int t;
    op_exp_t oe;
    res_exp_t re;
    bit last;
    if (!RST) begin
      chk("s_ready", s_ready, m_in_run);
      chk("ce_ab", ce_ab, m_in_run & s_valid);
      if (ce_m) begin
        if (cem_q.size() == 0) fail_now("ce_m");
        else begin t = cem_q.pop_front(); chk("ce_m_cycle", cyc, t); end
      end
      if (ce_p) begin
        if (op_q.size() == 0) fail_now("ce_p");
        else begin
          oe = op_q.pop_front();
          chk("ce_p_cycle", cyc, oe.t);
          chk("opmode", opmode, oe.op);
          m_last_op = oe.op;
        end
      end else begin
        chk("opmode_hold", opmode, m_last_op);
      end
      if (res_valid) begin
        m_res_cnt++;
        if (res_q.size() == 0) fail_now("res_valid");
        else begin
          re = res_q.pop_front();
          chk("res_cycle", cyc, re.t);
          chk("res_last", res_last, re.last);
          if (re.last) m_lastres_cyc = cyc;
        end
      end else begin
        chk("res_last_idle", res_last, 1'b0);
      end
      if (done) begin m_done_cnt++; m_done_cyc = cyc; end
      if (cmd_valid && cmd_ready) begin
        m_cmd_acc++; m_cmd_cyc = cyc; m_idx = 0; m_in_run = (m_len > 0);
      end else if (s_valid && s_ready) begin
        last = (m_idx == m_len - 1);
        cem_q.push_back(cyc + 1);
        op_q.push_back('{cyc + 2, (m_idx == 0) ? m_first_op : m_rest_op});
        if (m_mul || last) res_q.push_back('{cyc + 3, last});
        m_idx++;
        if (m_idx == m_len) m_in_run = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cmd_ready();
    int g = 0;
    while (!cmd_ready && g < 50) begin tick(); g++; end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
  endtask

  task automatic run_cmd(input vec_t v, input bit hold);
    int g;
    m_first_op = v.op_first; m_rest_op = v.op_rest;
    m_len = v.len; m_mul = (v.mode == 2'd0);
    m_res_cnt = 0; m_done_cnt = 0; m_cmd_acc = 0;
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_mode = v.mode; cmd_len = LEN_W'(v.len);
    tick();
    if (hold) begin cmd_mode = ~v.mode; cmd_len = LEN_W'(5); end
    else cmd_valid = 1'b0;
    g = 0;
    while (m_idx < v.len && g < 1000) begin
      s_valid = v.gap ? ((g % 2) == 0) : 1'b1;
      tick();
      g++;
    end
    s_valid = 1'b0;
    if (m_idx < v.len) fail_now("sample_timeout");
    g = 0;
    while (m_done_cnt == 0 && g < 50) begin tick(); g++; end
    cmd_valid = 1'b0;
    if (m_done_cnt == 0) fail_now("done_timeout");
    chk("cmd_ready_after_done", cmd_ready, 1'b1);
    chk("busy_after_done", busy, 1'b0);
    tick();
    chk("done_once", m_done_cnt, 1);
    chk("cmd_accepts", m_cmd_acc, 1);
    chk("res_count", m_res_cnt, v.exp_res);
    chk("pending", cem_q.size() + op_q.size() + res_q.size(), 0);
    if (v.len > 0) chk("done_cycle", m_done_cyc, m_lastres_cyc + 1);
    else           chk("done_cycle_len0", m_done_cyc, m_cmd_cyc + 1);
  endtask

  initial begin
    vecs[0] = '{2'd0,   3, 1'b0, 8'h01, 8'h01,   3};
    vecs[1] = '{2'd1,   4, 1'b1, 8'h01, 8'h09,   1};
    vecs[2] = '{2'd3,   2, 1'b0, 8'h51, 8'h59,   1};
    vecs[3] = '{2'd2,   2, 1'b0, 8'h11, 8'h19,   1};
    vecs[4] = '{2'd0,   0, 1'b0, 8'h01, 8'h01,   0};
    vecs[5] = '{2'd3,   0, 1'b0, 8'h51, 8'h59,   0};
    vecs[6] = '{2'd0,  15, 1'b1, 8'h01, 8'h01,  15};
    vecs[7] = '{2'd1,   1, 1'b0, 8'h01, 8'h09,   1};
    vecs[8] = '{2'd0, 255, 1'b0, 8'h01, 8'h01, 255};
    vecs[9] = '{2'd0,   1, 1'b0, 8'h01, 8'h01,   1};

    RST = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_len = '0; s_valid = 1'b0;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ce_p", ce_p, 1'b0);
    chk("rst_opmode", opmode, 8'h00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], 1'b0);

    // cmd_valid kept high through RUN with another mode must not be taken.
    run_cmd(vecs[1], 1'b1);

    // Reset after three accepts of a MAC len=8 command.
    m_first_op = 8'h01; m_rest_op = 8'h09; m_len = 8; m_mul = 1'b0;
    m_res_cnt = 0; m_done_cnt = 0;
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_mode = 2'd1; cmd_len = LEN_W'(8);
    tick();
    cmd_valid = 1'b0;
    s_valid = 1'b1;
    for (int g = 0; g < 20 && m_idx < 3; g++) tick();
    #1;
    s_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_cmd_ready", cmd_ready, 1'b1);
    chk("abort_ce_m", ce_m, 1'b0);
    chk("abort_ce_p", ce_p, 1'b0);
    chk("abort_opmode", opmode, 8'h00);
    chk("abort_res_valid", res_valid, 1'b0);
    cem_q.delete(); op_q.delete(); res_q.delete();
    m_in_run = 1'b0; m_last_op = 8'h00; m_len = 0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (5) tick();
    chk("abort_no_res", m_res_cnt, 0);
    chk("abort_no_done", m_done_cnt, 0);
    run_cmd(vecs[9], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
